// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//   Pipeline hazard and stall controller for the 5-stage MIPS core. It takes
//   the per-stage control bits produced by the decode controller and returns
//   the stall/flush controls for every pipeline register. It also produces
//   the operand forwarding selects for the E-stage ALU and the D-stage branch
//   comparator. It sequences two multi-cycle interlocks:
//     - a HI/LO divide busy interlock, which holds E for DIV_CYCLES cycles
//     - a data-SRAM wait FSM, which holds M until the SRAM acknowledges
//
// Parameters
//   RW          register address width
//   DIV_CYCLES  stall cycles for a div/divu resident in E (>= 2)
//   CNT_W       divide counter width, must hold DIV_CYCLES-1
//
// Ports
//   clk, rst                       core clock, synchronous active-high reset
//   i_rsD, i_rtD                   D-stage source registers
//   i_rsE, i_rtE                   E-stage source registers
//   i_writeregE/M/W                destination register per stage
//   i_regwriteE/M/W                stage writes the GPR file
//   i_memtoregE/M                  stage holds a load
//   i_branchD, i_jrD               branch / jr-jalr in D (resolved in D)
//   i_div_startE                   div/divu resident in E
//   i_dmem_reqM, i_dmem_okM        data SRAM request in M / SRAM acknowledge
//   o_forwardAE, o_forwardBE       00 regfile, 10 M ALU result, 01 W result
//   o_forwardAD, o_forwardBD       forward the M ALU result to the D comparator
//   o_stallF..o_stallW             hold the stage register
//   o_flushE, o_flushM, o_flushW   insert a bubble into the stage register
//   o_div_doneE                    one-cycle pulse: divide result valid
// -----------------------------------------------------------------------------
module hazard_unit #(
    parameter int RW         = 5,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [RW-1:0] i_rsD,
    input  logic [RW-1:0] i_rtD,
    input  logic [RW-1:0] i_rsE,
    input  logic [RW-1:0] i_rtE,
    input  logic [RW-1:0] i_writeregE,
    input  logic [RW-1:0] i_writeregM,
    input  logic [RW-1:0] i_writeregW,
    input  logic          i_regwriteE,
    input  logic          i_regwriteM,
    input  logic          i_regwriteW,
    input  logic          i_memtoregE,
    input  logic          i_memtoregM,
    input  logic          i_branchD,
    input  logic          i_jrD,
    input  logic          i_div_startE,
    input  logic          i_dmem_reqM,
    input  logic          i_dmem_okM,
    output logic [1:0]    o_forwardAE,
    output logic [1:0]    o_forwardBE,
    output logic          o_forwardAD,
    output logic          o_forwardBD,
    output logic          o_stallF,
    output logic          o_stallD,
    output logic          o_stallE,
    output logic          o_stallM,
    output logic          o_stallW,
    output logic          o_flushE,
    output logic          o_flushM,
    output logic          o_flushW,
    output logic          o_div_doneE
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {
        DIV_IDLE,
        DIV_BUSY
    } div_state_t;

    typedef enum logic {
        M_IDLE,
        M_WAIT
    } mem_state_t;

    div_state_t       r_div_state;
    div_state_t       w_div_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    mem_state_t       r_mem_state;
    mem_state_t       w_mem_next;

    logic w_memstall;
    logic w_divstall;
    logic w_div_done;
    logic w_lwstall;
    logic w_brstall;
    logic w_br_hitE;
    logic w_br_hitM;

    // E-stage forwarding select for one source operand; the newest producer
    // (M) wins over the older one (W), and $0 is never forwarded.
    function automatic logic [1:0] fwd_sel_e(
        input logic [RW-1:0] src,
        input logic          regwrite_m,
        input logic [RW-1:0] writereg_m,
        input logic          regwrite_w,
        input logic [RW-1:0] writereg_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src != '0) begin
            if (regwrite_m && (writereg_m == src))
                sel = 2'b10;
            else if (regwrite_w && (writereg_w == src))
                sel = 2'b01;
        end
        return sel;
    endfunction

    // ---------------------------------------------------------------------
    // Forwarding selects (purely combinational)
    // ---------------------------------------------------------------------
    always_comb begin
        o_forwardAE = fwd_sel_e(i_rsE, i_regwriteM, i_writeregM, i_regwriteW, i_writeregW);
        o_forwardBE = fwd_sel_e(i_rtE, i_regwriteM, i_writeregM, i_regwriteW, i_writeregW);
        o_forwardAD = (i_rsD != '0) && i_regwriteM && (i_writeregM == i_rsD);
        o_forwardBD = (i_rtD != '0) && i_regwriteM && (i_writeregM == i_rtD);
    end

    // ---------------------------------------------------------------------
    // Load-use and branch interlocks
    // ---------------------------------------------------------------------
    always_comb begin
        w_lwstall = i_memtoregE && ((i_rtE == i_rsD) || (i_rtE == i_rtD));

        // jr/jalr only reads rs in D; a branch compares rs and rt.
        w_br_hitE = i_regwriteE && (i_writeregE != '0) &&
                    ((i_writeregE == i_rsD) || (i_branchD && (i_writeregE == i_rtD)));
        // A load in M cannot forward its data to D, so it must also wait.
        w_br_hitM = i_memtoregM && (i_writeregM != '0) &&
                    ((i_writeregM == i_rsD) || (i_branchD && (i_writeregM == i_rtD)));

        w_brstall = (i_branchD || i_jrD) && (w_br_hitE || w_br_hitM);
    end

    // ---------------------------------------------------------------------
    // Data-SRAM wait FSM
    // ---------------------------------------------------------------------
    always_comb begin
        w_mem_next = r_mem_state;
        w_memstall = 1'b0;
        case (r_mem_state)
            M_IDLE: begin
                // An acknowledge in the request cycle costs no stall.
                w_memstall = i_dmem_reqM && !i_dmem_okM;
                if (w_memstall)
                    w_mem_next = M_WAIT;
            end
            M_WAIT: begin
                // The stall is released in the acknowledge cycle itself.
                w_memstall = !i_dmem_okM;
                if (i_dmem_okM)
                    w_mem_next = M_IDLE;
            end
            default: begin
                w_mem_next = M_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_mem_state <= M_IDLE;
        else
            r_mem_state <= w_mem_next;
    end

    // ---------------------------------------------------------------------
    // Divide busy FSM
    // ---------------------------------------------------------------------
    always_comb begin
        w_div_next = r_div_state;
        w_cnt_next = r_cnt;
        w_divstall = 1'b0;
        w_div_done = 1'b0;
        case (r_div_state)
            DIV_IDLE: begin
                if (i_div_startE) begin
                    w_divstall = 1'b1;
                    w_cnt_next = DIV_LAST;
                    w_div_next = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                if (r_cnt != '0) begin
                    w_divstall = 1'b1;
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    // div_startE is deliberately ignored here: the divide
                    // that just finished is still the one sitting in E.
                    w_div_done = 1'b1;
                    w_div_next = DIV_IDLE;
                end
            end
            default: begin
                w_div_next = DIV_IDLE;
            end
        endcase
    end

    // The divider is frozen while memory holds the pipe, so a done pulse
    // that would fall inside a memory wait is deferred, not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_state <= DIV_IDLE;
            r_cnt       <= '0;
        end else if (!w_memstall) begin
            r_div_state <= w_div_next;
            r_cnt       <= w_cnt_next;
        end
    end

    // ---------------------------------------------------------------------
    // Stall / flush priority: memory > divide > load-use/branch
    // ---------------------------------------------------------------------
    always_comb begin
        o_stallF    = 1'b0;
        o_stallD    = 1'b0;
        o_stallE    = 1'b0;
        o_stallM    = 1'b0;
        o_stallW    = 1'b0;
        o_flushE    = 1'b0;
        o_flushM    = 1'b0;
        o_flushW    = 1'b0;
        o_div_doneE = 1'b0;
        if (!rst) begin
            if (w_memstall) begin
                o_stallF = 1'b1;
                o_stallD = 1'b1;
                o_stallE = 1'b1;
                o_stallM = 1'b1;
                o_flushW = 1'b1;
            end else if (w_divstall) begin
                o_stallF = 1'b1;
                o_stallD = 1'b1;
                o_stallE = 1'b1;
                o_flushM = 1'b1;
            end else begin
                o_div_doneE = w_div_done;
                if (w_lwstall || w_brstall) begin
                    o_stallF = 1'b1;
                    o_stallD = 1'b1;
                    o_flushE = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

    localparam int RW         = 5;
    localparam int DIV_CYCLES = 32;
    localparam int CNT_W      = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic          regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic          branchD, jrD, div_startE, dmem_reqM, dmem_okM;
    logic [1:0]    forwardAE, forwardBE;
    logic          forwardAD, forwardBD;
    logic          stallF, stallD, stallE, stallM, stallW;
    logic          flushE, flushM, flushW, div_doneE;

    always #5 clk = ~clk;

    hazard_unit #(.RW(RW), .DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .i_rsD(rsD), .i_rtD(rtD), .i_rsE(rsE), .i_rtE(rtE),
        .i_writeregE(writeregE), .i_writeregM(writeregM), .i_writeregW(writeregW),
        .i_regwriteE(regwriteE), .i_regwriteM(regwriteM), .i_regwriteW(regwriteW),
        .i_memtoregE(memtoregE), .i_memtoregM(memtoregM),
        .i_branchD(branchD), .i_jrD(jrD), .i_div_startE(div_startE),
        .i_dmem_reqM(dmem_reqM), .i_dmem_okM(dmem_okM),
        .o_forwardAE(forwardAE), .o_forwardBE(forwardBE),
        .o_forwardAD(forwardAD), .o_forwardBD(forwardBD),
        .o_stallF(stallF), .o_stallD(stallD), .o_stallE(stallE),
        .o_stallM(stallM), .o_stallW(stallW),
        .o_flushE(flushE), .o_flushM(flushM), .o_flushW(flushW),
        .o_div_doneE(div_doneE)
    );

    // Expected outputs, packed as
    // {fAE[1:0], fBE[1:0], fAD, fBD, stF, stD, stE, stM, stW, flE, flM, flW, done}
    typedef struct {
        logic [14:0] vec;
        int          cyc;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cycle    = 0;
    string phase   = "reset";

    // Reference model state: whether a divide is in progress and how many
    // stall cycles it has already consumed; whether memory is waiting.
    bit m_div_busy  = 0;
    int m_div_spent = 0;
    bit m_mem_wait  = 0;

    function automatic logic [1:0] ref_fwd_e(input logic [RW-1:0] src);
        if (src == 0) return 2'b00;
        if (regwriteM && writeregM == src) return 2'b10;
        if (regwriteW && writeregW == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit in_branch_srcs(input logic [RW-1:0] r);
        logic [RW-1:0] srcs[$];
        srcs.push_back(rsD);
        if (branchD) srcs.push_back(rtD);
        foreach (srcs[i]) if (srcs[i] == r) return 1;
        return 0;
    endfunction

    task automatic clear_inputs();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeregE = 0; writeregM = 0; writeregW = 0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0;
        memtoregE = 0; memtoregM = 0; branchD = 0; jrD = 0;
        div_startE = 0; dmem_reqM = 0; dmem_okM = 0;
    endtask

    // Apply the currently driven inputs for one clock cycle: predict the
    // outputs, queue the prediction, then advance the model past the edge.
    task automatic tick();
        exp_t e;
        bit memstall, divstall, done, lw, br;
        bit sF, sD, sE, sM, fE, fM, fW, dn;
        memstall = m_mem_wait ? !dmem_okM : (dmem_reqM && !dmem_okM);
        divstall = 0;
        done     = 0;
        if (!m_div_busy) divstall = div_startE;
        else if (m_div_spent < DIV_CYCLES) divstall = 1;
        else done = 1;
        lw = memtoregE && (rtE == rsD || rtE == rtD);
        br = (branchD || jrD) &&
             ((regwriteE && writeregE != 0 && in_branch_srcs(writeregE)) ||
              (memtoregM && writeregM != 0 && in_branch_srcs(writeregM)));
        {sF, sD, sE, sM, fE, fM, fW, dn} = '0;
        if (!rst) begin
            if (memstall) begin
                sF = 1; sD = 1; sE = 1; sM = 1; fW = 1;
            end else if (divstall) begin
                sF = 1; sD = 1; sE = 1; fM = 1;
            end else begin
                dn = done;
                if (lw || br) begin sF = 1; sD = 1; fE = 1; end
            end
        end
        e.vec = {ref_fwd_e(rsE), ref_fwd_e(rtE),
                 logic'(rsD != 0 && regwriteM && writeregM == rsD),
                 logic'(rtD != 0 && regwriteM && writeregM == rtD),
                 sF, sD, sE, sM, 1'b0, fE, fM, fW, dn};
        e.cyc = cycle;
        e.tag = phase;
        sb.push_back(e);

        if (rst) begin
            m_div_busy = 0; m_div_spent = 0; m_mem_wait = 0;
        end else begin
            m_mem_wait = memstall;
            if (!memstall) begin
                if (!m_div_busy) begin
                    if (div_startE) begin m_div_busy = 1; m_div_spent = 1; end
                end else if (m_div_spent < DIV_CYCLES) begin
                    m_div_spent++;
                end else begin
                    m_div_busy = 0; m_div_spent = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    // Monitor: outputs are presented every cycle; sample mid-cycle.
    initial begin
        exp_t e;
        logic [14:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                act = {forwardAE, forwardBE, forwardAD, forwardBD, stallF, stallD,
                       stallE, stallM, stallW, flushE, flushM, flushW, div_doneE};
                n_checks++;
                if (act === e.vec) n_pass++;
                else $display("FAIL %s cycle %0d: got %b expected %b (fAE fBE fAD fBD sF sD sE sM sW fE fM fW done)",
                              e.tag, e.cyc, act, e.vec);
            end
        end
    end

    initial begin
        clear_inputs();
        rst = 1;
        @(posedge clk);
        #1;
        tick(); tick();
        rst = 0;

        // load-use: lw $2 in E, add $3,$2,$4 in D; then add in E with lw in M/W
        phase = "loaduse";
        memtoregE = 1; regwriteE = 1; writeregE = 2; rtE = 2; rsD = 2; rtD = 4;
        tick();
        clear_inputs();
        memtoregM = 1; regwriteM = 1; writeregM = 2; rsE = 2; rtE = 4;
        tick();
        clear_inputs();
        regwriteW = 1; writeregW = 2; rsE = 2; rtE = 4;
        tick();

        // forwarding priority and $0
        phase = "forward";
        clear_inputs();
        regwriteM = 1; writeregM = 5; regwriteW = 1; writeregW = 5; rsE = 5; rtE = 5;
        tick();
        writeregM = 0; writeregW = 0; rsE = 0; rtE = 0;
        tick();
        writeregM = 7; writeregW = 5; rsE = 5; rtE = 7;
        tick();

        // branch interlock then D forwarding
        phase = "branch";
        clear_inputs();
        branchD = 1; rsD = 6; rtD = 1; regwriteE = 1; writeregE = 6;
        tick();
        clear_inputs();
        branchD = 1; rsD = 6; rtD = 1; regwriteM = 1; writeregM = 6;
        tick();
        clear_inputs();
        jrD = 1; rsD = 3; rtD = 9; regwriteE = 1; writeregE = 9;
        tick();
        memtoregM = 1; regwriteE = 0; writeregM = 3;
        tick();

        // clean divide, start held high through the done cycle
        phase = "divide";
        clear_inputs();
        div_startE = 1;
        repeat (DIV_CYCLES + 1) tick();
        div_startE = 0;
        repeat (2) tick();

        // memory wait: 3 cycles then ack; then same-cycle ack
        phase = "memwait";
        dmem_reqM = 1; dmem_okM = 0;
        repeat (3) tick();
        dmem_okM = 1;
        tick();
        dmem_reqM = 1; dmem_okM = 1;
        tick();
        clear_inputs();
        tick();

        // memory wait during a divide, then reset mid-wait
        phase = "divmem";
        div_startE = 1;
        repeat (22) tick();
        dmem_reqM = 1; dmem_okM = 0;
        repeat (4) tick();
        rst = 1;
        tick();
        rst = 0;
        clear_inputs();
        repeat (3) tick();
        div_startE = 1;
        repeat (20) tick();
        dmem_reqM = 1;
        repeat (15) tick();
        dmem_okM = 1;
        repeat (2) tick();
        dmem_reqM = 0;
        repeat (2) tick();
        div_startE = 0;
        tick();

        // randomized traffic
        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 79) == 0);
            rsD        = RW'($urandom_range(0, 3));
            rtD        = RW'($urandom_range(0, 3));
            rsE        = RW'($urandom_range(0, 3));
            rtE        = RW'($urandom_range(0, 3));
            writeregE  = RW'($urandom_range(0, 3));
            writeregM  = RW'($urandom_range(0, 3));
            writeregW  = RW'($urandom_range(0, 3));
            regwriteE  = 1'($urandom_range(0, 1));
            regwriteM  = 1'($urandom_range(0, 1));
            regwriteW  = 1'($urandom_range(0, 1));
            memtoregE  = ($urandom_range(0, 3) == 0);
            memtoregM  = ($urandom_range(0, 3) == 0);
            branchD    = ($urandom_range(0, 2) == 0);
            jrD        = ($urandom_range(0, 4) == 0);
            div_startE = ($urandom_range(0, 24) == 0);
            dmem_reqM  = ($urandom_range(0, 3) == 0);
            dmem_okM   = 1'($urandom_range(0, 1));
            tick();
        end

        rst = 0;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
